// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//   Shared constants for the BlockRam bus arbiter: default memory widths,
//   watchdog defaults, FSM state encoding, grant encodings and the
//   round-robin pick helper.
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    localparam int DEFAULT_MADDR_WIDTH       = 10;
    localparam int DEFAULT_MDATA_WIDTH       = 16;
    localparam int DEFAULT_ARB_TIMEOUT       = 256;
    localparam int DEFAULT_ARB_TIMEOUT_WIDTH = 9;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_R0   = 2'b01;
    localparam logic [1:0] GRANT_R1   = 2'b10;

    // Returns the index of the requester to grant (0 or 1). With both
    // requesting, the one that did not own the bus last time wins.
    function automatic logic pick_owner(input logic req0,
                                        input logic req1,
                                        input logic last_owner);
        if (req0 && req1)
            return ~last_owner;
        return req1;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// -----------------------------------------------------------------------------
// arb_watchdog
//   Counts enabled cycles since the last clear. expire is asserted during the
//   LIMIT-th consecutive enabled, uncleared cycle, so an owner that sees no
//   ready is released after exactly LIMIT granted cycles.
//
// Ports
//   clock   in   system clock, rising edge
//   reset   in   asynchronous, active-low reset
//   clear   in   synchronous clear of the count (wins over enable)
//   enable  in   count this cycle
//   expire  out  terminal count reached this cycle
// -----------------------------------------------------------------------------
module arb_watchdog #(
    parameter int LIMIT = 256,
    parameter int WIDTH = 9
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [WIDTH-1:0] count;
    logic             at_limit;

    assign at_limit = (count == WIDTH'(LIMIT - 1));
    assign expire   = enable && !clear && at_limit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_limit) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares the single BlockRam port between the graph loader (requester 0)
//   and DijkstraTop (requester 1) with a registered one-hot grant and
//   combinational muxes. Each requester keeps the native BlockRam handshake:
//   raise an enable, hold it until ready, then drop it.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ARB_IDLE   | no owner; memory enables low; arbitrate at the next edge
//   ARB_GRANT0 | requester 0 owns the memory port
//   ARB_GRANT1 | requester 1 owns the memory port
//
// Ports
//   clock, reset                 clock (rising edge), async active-low reset
//   rN_read_enable/write_enable  request enables from requester N
//   rN_addr, rN_write_data       request address / write data
//   rN_read_ready/write_ready    memory readies, forwarded to the owner only
//   rN_read_data                 memory read data, zero when not owner
//   mem_*                        BlockRam port
//   grant                        one-hot owner (01 = r0, 10 = r1, 00 = none)
//   timeout_error                sticky, set on a watchdog forced release
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MADDR_WIDTH    = DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH    = DEFAULT_MDATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_ARB_TIMEOUT,
    parameter int TIMEOUT_WIDTH  = DEFAULT_ARB_TIMEOUT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   r0_read_enable,
    input  logic                   r0_write_enable,
    input  logic [MADDR_WIDTH-1:0] r0_addr,
    input  logic [MDATA_WIDTH-1:0] r0_write_data,
    output logic                   r0_read_ready,
    output logic                   r0_write_ready,
    output logic [MDATA_WIDTH-1:0] r0_read_data,

    input  logic                   r1_read_enable,
    input  logic                   r1_write_enable,
    input  logic [MADDR_WIDTH-1:0] r1_addr,
    input  logic [MDATA_WIDTH-1:0] r1_write_data,
    output logic                   r1_read_ready,
    output logic                   r1_write_ready,
    output logic [MDATA_WIDTH-1:0] r1_read_data,

    output logic                   mem_read_enable,
    output logic                   mem_write_enable,
    output logic [MADDR_WIDTH-1:0] mem_addr,
    output logic [MDATA_WIDTH-1:0] mem_write_data,
    input  logic                   mem_read_ready,
    input  logic                   mem_write_ready,
    input  logic [MDATA_WIDTH-1:0] mem_read_data,

    output logic [1:0]             grant,
    output logic                   timeout_error
);

    arb_state_t state;
    logic       last_owner;
    logic       req0;
    logic       req1;
    logic       owner_req;
    logic       next_owner;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expire;

    assign req0       = r0_read_enable | r0_write_enable;
    assign req1       = r1_read_enable | r1_write_enable;
    assign next_owner = pick_owner(req0, req1, last_owner);

    always_comb begin
        owner_req = 1'b0;
        case (state)
            ARB_GRANT0: owner_req = req0;
            ARB_GRANT1: owner_req = req1;
            default:    owner_req = 1'b0;
        endcase
    end

    // The count restarts in IDLE, which also covers the entry into GRANTx,
    // and on any ready from the memory.
    assign wd_enable = (state != ARB_IDLE);
    assign wd_clear  = (state == ARB_IDLE) || mem_read_ready || mem_write_ready;

    arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // -------------------------------------------------------------------------
    // FSM: state, grant, round-robin pointer and sticky error.
    // A release always passes through IDLE so the memory sees its enables low
    // for at least one cycle before the next owner is connected.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ARB_IDLE;
            grant         <= GRANT_NONE;
            last_owner    <= 1'b1;
            timeout_error <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (req0 || req1) begin
                        last_owner <= next_owner;
                        if (next_owner) begin
                            state <= ARB_GRANT1;
                            grant <= GRANT_R1;
                        end else begin
                            state <= ARB_GRANT0;
                            grant <= GRANT_R0;
                        end
                    end
                end
                ARB_GRANT0, ARB_GRANT1: begin
                    if (!owner_req) begin
                        state <= ARB_IDLE;
                        grant <= GRANT_NONE;
                    end else if (wd_expire) begin
                        state         <= ARB_IDLE;
                        grant         <= GRANT_NONE;
                        timeout_error <= 1'b1;
                        // Offender keeps the pointer so the other side wins next.
                        last_owner    <= (state == ARB_GRANT1);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    grant <= GRANT_NONE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Bus muxes, purely combinational on the grant register. A write wins over
    // a simultaneous read from the same owner.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_addr         = '0;
        mem_write_data   = '0;
        r0_read_ready    = 1'b0;
        r0_write_ready   = 1'b0;
        r0_read_data     = '0;
        r1_read_ready    = 1'b0;
        r1_write_ready   = 1'b0;
        r1_read_data     = '0;
        case (grant)
            GRANT_R0: begin
                mem_write_enable = r0_write_enable;
                mem_read_enable  = r0_read_enable & ~r0_write_enable;
                mem_addr         = r0_addr;
                mem_write_data   = r0_write_data;
                r0_read_ready    = mem_read_ready;
                r0_write_ready   = mem_write_ready;
                r0_read_data     = mem_read_data;
            end
            GRANT_R1: begin
                mem_write_enable = r1_write_enable;
                mem_read_enable  = r1_read_enable & ~r1_write_enable;
                mem_addr         = r1_addr;
                mem_write_data   = r1_write_data;
                r1_read_ready    = mem_read_ready;
                r1_write_ready   = mem_write_ready;
                r1_read_data     = mem_read_data;
            end
            default: begin
                mem_read_enable  = 1'b0;
                mem_write_enable = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          r0_read_enable, r0_write_enable;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_write_data;
    logic          r0_read_ready, r0_write_ready;
    logic [DW-1:0] r0_read_data;
    logic          r1_read_enable, r1_write_enable;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_write_data;
    logic          r1_read_ready, r1_write_ready;
    logic [DW-1:0] r1_read_data;
    logic          mem_read_enable, mem_write_enable;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_read_ready  = 1'b0;
    logic          mem_write_ready = 1'b0;
    logic [DW-1:0] mem_read_data   = '0;
    logic [1:0]    grant;
    logic          timeout_error;

    int checks = 0;
    int errors = 0;
    bit stub_mode = 1'b0;

    logic [DW-1:0] mem_arr [0:(1<<AW)-1];

    logic [1:0] grant_seq[$];
    int         gap_seq[$];
    int         direct_switch;

    mem_bus_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .r0_read_enable   (r0_read_enable),
        .r0_write_enable  (r0_write_enable),
        .r0_addr          (r0_addr),
        .r0_write_data    (r0_write_data),
        .r0_read_ready    (r0_read_ready),
        .r0_write_ready   (r0_write_ready),
        .r0_read_data     (r0_read_data),
        .r1_read_enable   (r1_read_enable),
        .r1_write_enable  (r1_write_enable),
        .r1_addr          (r1_addr),
        .r1_write_data    (r1_write_data),
        .r1_read_ready    (r1_read_ready),
        .r1_write_ready   (r1_write_ready),
        .r1_read_data     (r1_read_data),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_read_ready   (mem_read_ready),
        .mem_write_ready  (mem_write_ready),
        .mem_read_data    (mem_read_data),
        .grant            (grant),
        .timeout_error    (timeout_error)
    );

    always #5 clock = ~clock;

    // BlockRam model: one-cycle latency, ready held while the enable is held.
    always @(posedge clock) begin
        if (mem_write_enable && !stub_mode) begin
            if (!mem_write_ready) mem_arr[mem_addr] <= mem_write_data;
            mem_write_ready <= 1'b1;
        end else begin
            mem_write_ready <= 1'b0;
        end
        if (mem_read_enable && !stub_mode) begin
            mem_read_data  <= mem_arr[mem_addr];
            mem_read_ready <= 1'b1;
        end else begin
            mem_read_ready <= 1'b0;
        end
    end

    task automatic drop_all();
        r0_read_enable = 0; r0_write_enable = 0; r0_addr = '0; r0_write_data = '0;
        r1_read_enable = 0; r1_write_enable = 0; r1_addr = '0; r1_write_data = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        drop_all();
        stub_mode = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Issue one transaction from requester `who`; call off-edge. Returns at the
    // negedge where ready was seen, with the enables already dropped.
    task automatic do_txn(input int who, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int max_cyc, output logic [DW-1:0] q, output bit ok);
        ok = 1'b0;
        q  = '0;
        if (who == 0) begin
            r0_read_enable = rd; r0_write_enable = wr; r0_addr = a; r0_write_data = d;
        end else begin
            r1_read_enable = rd; r1_write_enable = wr; r1_addr = a; r1_write_data = d;
        end
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clock);
            if (who == 0) begin
                if ((wr && r0_write_ready) || (!wr && r0_read_ready)) begin
                    ok = 1'b1; q = r0_read_data;
                end
            end else begin
                if ((wr && r1_write_ready) || (!wr && r1_read_ready)) begin
                    ok = 1'b1; q = r1_read_data;
                end
            end
            if (ok) break;
        end
        if (who == 0) begin
            r0_read_enable = 0; r0_write_enable = 0;
        end else begin
            r1_read_enable = 0; r1_write_enable = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drop_all();
        r0_write_enable = 1; r0_addr = 10'd9; r0_write_data = 16'h1234;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout_error); end
        checks++; if (mem_write_enable !== 1'b0 || mem_read_enable !== 1'b0) begin
            errors++; $display("FAIL reset_mem_en got w%b r%b exp 0 0", mem_write_enable, mem_read_enable); end
        checks++; if (mem_addr !== '0 || mem_write_data !== '0) begin
            errors++; $display("FAIL reset_mem_bus got a%h d%h exp 0 0", mem_addr, mem_write_data); end
        checks++; if (r0_write_ready !== 1'b0 || r0_read_data !== '0) begin
            errors++; $display("FAIL reset_r0_out got rdy%b data%h exp 0 0", r0_write_ready, r0_read_data); end
        drop_all();
    endtask

    task automatic test_single_writer();
        logic [DW-1:0] q;
        bit ok;
        apply_reset();
        r0_write_enable = 1; r0_addr = 10'd5; r0_write_data = 16'd42;
        @(posedge clock); #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL sw_grant got %b exp 01", grant); end
        checks++; if (mem_write_enable !== 1'b1 || mem_read_enable !== 1'b0 || mem_addr !== 10'd5 || mem_write_data !== 16'd42) begin
            errors++; $display("FAIL sw_mem_bus got w%b r%b a%0d d%0d exp 1 0 5 42",
                               mem_write_enable, mem_read_enable, mem_addr, mem_write_data); end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (r0_write_ready) begin ok = 1'b1; break; end
            checks++; if (mem_write_enable !== 1'b1) begin errors++; $display("FAIL sw_hold_wen got %b exp 1", mem_write_enable); end
        end
        checks++; if (!ok) begin errors++; $display("FAIL sw_ready got none exp write_ready"); end
        r0_write_enable = 0;
        @(posedge clock); #1;
        checks++; if (grant !== 2'b00 || mem_write_enable !== 1'b0) begin
            errors++; $display("FAIL sw_release got grant %b wen %b exp 00 0", grant, mem_write_enable); end
        @(posedge clock); #1;
        do_txn(0, 1, 0, 10'd5, '0, 20, q, ok);
        checks++; if (!ok || q !== 16'd42) begin errors++; $display("FAIL sw_readback got ok%0d %0d exp 1 42", ok, q); end
        @(posedge clock); #1;
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] q;
        bit ok;
        apply_reset();
        do_txn(0, 0, 1, 10'd3, 16'h0033, 20, q, ok);
        @(posedge clock); #1;
        do_txn(0, 0, 1, 10'd7, 16'h0077, 20, q, ok);
        @(posedge clock); #1;
        apply_reset();
        r0_read_enable = 1; r0_addr = 10'd3;
        r1_read_enable = 1; r1_addr = 10'd7;
        @(posedge clock); #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL sim_first_grant got %b exp 01", grant); end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++; if (r1_read_ready !== 1'b0 || r1_read_data !== '0) begin
                errors++; $display("FAIL sim_r1_blocked got rdy%b data%h exp 0 0", r1_read_ready, r1_read_data); end
            if (r0_read_ready) begin ok = 1'b1; q = r0_read_data; break; end
        end
        checks++; if (!ok || q !== 16'h0033) begin errors++; $display("FAIL sim_r0_data got ok%0d %h exp 1 0033", ok, q); end
        r0_read_enable = 0;
        @(posedge clock); #1;
        checks++; if (grant !== 2'b00 || r1_read_ready !== 1'b0) begin
            errors++; $display("FAIL sim_idle got grant %b rdy %b exp 00 0", grant, r1_read_ready); end
        @(posedge clock); #1;
        checks++; if (grant !== 2'b10 || mem_addr !== 10'd7) begin
            errors++; $display("FAIL sim_second_grant got %b a%0d exp 10 7", grant, mem_addr); end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (r1_read_ready) begin ok = 1'b1; q = r1_read_data; break; end
        end
        checks++; if (!ok || q !== 16'h0077) begin errors++; $display("FAIL sim_r1_data got ok%0d %h exp 1 0077", ok, q); end
        r1_read_enable = 0;
        @(posedge clock); #1;
    endtask

    task automatic rr_requester(input int who, input int n, output int nok);
        logic [DW-1:0] q;
        bit ok;
        nok = 0;
        for (int i = 0; i < n; i++) begin
            do_txn(who, 1, 0, AW'(who * 16 + i), '0, 100, q, ok);
            if (ok) nok++;
            @(posedge clock); #1;
        end
    endtask

    task automatic rr_monitor(input int cycles);
        logic [1:0] prev, g;
        int idle_run;
        bit seen;
        prev = 2'b00; idle_run = 0; seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            g = grant;
            if (g != 2'b00 && prev != 2'b00 && g != prev) direct_switch++;
            if (g != 2'b00 && g != prev) begin
                grant_seq.push_back(g);
                if (prev == 2'b00 && seen) gap_seq.push_back(idle_run);
                seen = 1'b1;
            end
            if (g == 2'b00) idle_run++;
            else idle_run = 0;
            prev = g;
        end
    endtask

    task automatic test_round_robin();
        int nok0, nok1;
        logic [1:0] exp_g;
        apply_reset();
        grant_seq.delete();
        gap_seq.delete();
        direct_switch = 0;
        fork
            rr_requester(0, 4, nok0);
            rr_requester(1, 4, nok1);
            rr_monitor(45);
        join
        checks++; if (nok0 != 4 || nok1 != 4) begin errors++; $display("FAIL rr_done got %0d %0d exp 4 4", nok0, nok1); end
        checks++; if (grant_seq.size() != 8) begin errors++; $display("FAIL rr_count got %0d exp 8", grant_seq.size()); end
        for (int i = 0; i < grant_seq.size(); i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (grant_seq[i] !== exp_g) begin errors++; $display("FAIL rr_order[%0d] got %b exp %b", i, grant_seq[i], exp_g); end
        end
        checks++; if (gap_seq.size() != 7) begin errors++; $display("FAIL rr_gaps got %0d exp 7", gap_seq.size()); end
        for (int i = 0; i < gap_seq.size(); i++) begin
            checks++; if (gap_seq[i] != 1) begin errors++; $display("FAIL rr_gap[%0d] got %0d exp 1", i, gap_seq[i]); end
        end
        checks++; if (direct_switch != 0) begin errors++; $display("FAIL rr_no_idle got %0d exp 0", direct_switch); end
    endtask

    task automatic test_both_enables();
        logic [DW-1:0] q;
        bit ok;
        apply_reset();
        r1_read_enable = 1; r1_write_enable = 1; r1_addr = 10'd2; r1_write_data = 16'd9;
        @(posedge clock); #1;
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL both_grant got %b exp 10", grant); end
        checks++; if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b1 || mem_addr !== 10'd2 || mem_write_data !== 16'd9) begin
            errors++; $display("FAIL both_mem_bus got r%b w%b a%0d d%0d exp 0 1 2 9",
                               mem_read_enable, mem_write_enable, mem_addr, mem_write_data); end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (r1_write_ready) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL both_ready got none exp write_ready"); end
        r1_read_enable = 0; r1_write_enable = 0;
        @(posedge clock); #1;
        do_txn(1, 1, 0, 10'd2, '0, 20, q, ok);
        checks++; if (!ok || q !== 16'd9) begin errors++; $display("FAIL both_readback got ok%0d %0d exp 1 9", ok, q); end
        @(posedge clock); #1;
    endtask

    task automatic test_watchdog();
        logic [DW-1:0] q;
        bit ok;
        int n;
        apply_reset();
        stub_mode = 1'b1;
        r0_write_enable = 1; r0_addr = 10'd1; r0_write_data = 16'h0055;
        r1_read_enable  = 1; r1_addr = 10'd7;
        @(posedge clock); #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL wd_first_grant got %b exp 01", grant); end
        n = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            if (grant === 2'b01) n++;
            else break;
        end
        checks++; if (n != 256) begin errors++; $display("FAIL wd_granted_cycles got %0d exp 256", n); end
        checks++; if (grant !== 2'b00 || timeout_error !== 1'b1) begin
            errors++; $display("FAIL wd_release got grant %b err %b exp 00 1", grant, timeout_error); end
        stub_mode = 1'b0;
        @(posedge clock); #1;
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL wd_r1_next got %b exp 10", grant); end
        ok = 1'b0; q = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (r1_read_ready) begin ok = 1'b1; q = r1_read_data; break; end
        end
        checks++; if (!ok || q !== 16'h0077) begin errors++; $display("FAIL wd_r1_data got ok%0d %h exp 1 0077", ok, q); end
        drop_all();
        repeat (4) @(posedge clock);
        #1;
        checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b exp 1", timeout_error); end
        apply_reset();
        #1;
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL wd_cleared got %b exp 0", timeout_error); end
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        r1_write_enable = 1; r1_addr = 10'd4; r1_write_data = 16'h00AA;
        @(posedge clock); #1;
        checks++; if (grant !== 2'b10 || mem_write_enable !== 1'b1) begin
            errors++; $display("FAIL rmw_grant got %b wen %b exp 10 1", grant, mem_write_enable); end
        @(posedge clock); #1;
        checks++; if (r1_write_ready !== 1'b1) begin errors++; $display("FAIL rmw_ready_before got %b exp 1", r1_write_ready); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (mem_write_enable !== 1'b0 || grant !== 2'b00) begin
            errors++; $display("FAIL rmw_async got wen %b grant %b exp 0 00", mem_write_enable, grant); end
        checks++; if (r1_write_ready !== 1'b0 || r1_read_ready !== 1'b0 || r0_write_ready !== 1'b0 || r0_read_ready !== 1'b0) begin
            errors++; $display("FAIL rmw_readies got %b%b%b%b exp 0000",
                               r1_write_ready, r1_read_ready, r0_write_ready, r0_read_ready); end
        r0_read_enable = 1; r0_addr = 10'd3;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmw_after_grant got %b exp 01", grant); end
        drop_all();
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drop_all();
        test_reset();
        test_single_writer();
        test_simultaneous();
        test_round_robin();
        test_both_enables();
        test_watchdog();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester arbiter sharing the single BlockRam port between the graph loader (requester 0, host/bench side) and DijkstraTop (requester 1).
- Replaces the tristate sharing of mem_addr, mem_*_enable and mem_write_data with an explicit registered grant and a mux.
- Each requester keeps the native BlockRam handshake:
  - raise the enable and hold it until ready;
  - then drop the enable.

Parameters:
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH, memory address width.
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH, memory data width.
- TIMEOUT_CYCLES, 256, maximum granted cycles without a memory ready before a forced release.
- TIMEOUT_WIDTH, 9, width of the watchdog counter; must satisfy 2**TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- r0_read_enable, r1_read_enable  in  1 each  read request from requester 0 / 1.
- r0_write_enable, r1_write_enable  in  1 each  write request.
- r0_addr, r1_addr  in  MADDR_WIDTH each  request address.
- r0_write_data, r1_write_data  in  MDATA_WIDTH each  write data.
- r0_read_ready, r1_read_ready  out  1 each  read-ready, forwarded only to the granted requester.
- r0_write_ready, r1_write_ready  out  1 each  write-ready, forwarded only to the granted requester.
- r0_read_data, r1_read_data  out  MDATA_WIDTH each  read data; zero when not granted.
- mem_read_enable  out  1  to BlockRam.
- mem_write_enable  out  1  to BlockRam.
- mem_addr  out  MADDR_WIDTH  to BlockRam.
- mem_write_data  out  MDATA_WIDTH  to BlockRam.
- mem_read_ready  in  1  from BlockRam.
- mem_write_ready  in  1  from BlockRam.
- mem_read_data  in  MDATA_WIDTH  from BlockRam.
- grant  out  2  one-hot current owner: 01 = r0, 10 = r1, 00 = none.
- timeout_error  out  1  sticky; set when a grant is force-released.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, grant = 00, last_owner = 1 (so r0 wins the first tie), watchdog = 0, timeout_error = 0.
  - All mem_* outputs, r*_ready outputs and r*_read_data read 0 while reset is asserted.
  - A reset mid-transaction aborts the transaction immediately; memory enables drop asynchronously.
- A requester is "requesting" when its read_enable OR write_enable is high.
- State IDLE:
  - Sample requests at the rising edge.
  - Only one requester active: grant it.
  - Both active: grant the one that is not last_owner (round-robin).
  - Next state GRANT0 or GRANT1; last_owner is updated on grant.
- State GRANT0 / GRANT1:
  - mem_* is driven combinationally from the owner's inputs, so the memory sees the request 1 cycle after it is first sampled.
  - If the owner asserts both enables, the write wins: mem_read_enable is forced 0.
  - mem_read_ready, mem_write_ready and mem_read_data pass combinationally to the owner only (0 latency).
  - The other requester sees ready = 0 and read_data = 0, and must keep holding its request.
- Release:
  - When the owner has both enables low at a rising edge, go to IDLE and clear grant.
  - IDLE always lasts at least 1 cycle with memory enables low, so BlockRam re-arms.
  - Back-to-back transactions from the same requester therefore cost 1 idle cycle plus re-arbitration.
  - A waiting requester is granted on the edge that ends the IDLE cycle.
- Watchdog:
  - Counts the cycles in GRANTx in which neither mem ready is high; it clears on any ready and on entry to GRANTx.
  - When it reaches TIMEOUT_CYCLES: set timeout_error and force IDLE.
  - The offending owner then becomes last_owner, so the other requester gets priority.
  - timeout_error clears only on reset.
- Simultaneous release by the owner and a new request from the other requester: release first (IDLE), grant next edge.
- The enable inputs are sampled only at rising edges; the address and data muxes are purely combinational on the grant register.

Decomposition:
- Shared constants header (the existing constants.v): DEFAULT_MADDR_WIDTH, DEFAULT_MDATA_WIDTH.
- Add to that header: DEFAULT_ARB_TIMEOUT (256) and state encodings ARB_IDLE = 2'd0, ARB_GRANT0 = 2'd1, ARB_GRANT1 = 2'd2.
- One natural sub-module, arb_watchdog: counter with clear/enable inputs and a terminal-count output.
- The FSM, round-robin pointer and muxes stay in mem_bus_arbiter.

Test Plan:
- Single writer: r0 writes 42 to address 5. Expected:
  - grant = 01 one cycle after the request;
  - mem_write_enable high until mem_write_ready;
  - after r0 drops its enable, grant = 00 for 1 cycle;
  - an r0 read of address 5 returns 42.
- Simultaneous requests from reset: r0 reads address 3 and r1 reads address 7 together. Expected:
  - r0 is granted first;
  - r1_read_ready stays 0 throughout;
  - after r0 releases: 1 IDLE cycle, then grant = 10, and r1 receives the data at address 7.
- Round-robin fairness: both requesters issue back-to-back requests continuously for 8 transactions. Expected: grant alternates 01, 10, 01, … with exactly one IDLE cycle between grants.
- Both enables high: r1 asserts read and write together to address 2 with data 9. Expected:
  - mem_read_enable = 0, mem_write_enable = 1;
  - memory address 2 holds 9 afterwards.
- Watchdog: a stub memory never asserts ready while r0 is granted. Expected:
  - after 256 cycles, timeout_error = 1 and grant = 00;
  - a pending r1 request is granted next;
  - timeout_error stays 1 until reset.
- Reset mid-write: drive reset low during an r1 write. Expected:
  - mem_write_enable, grant and all ready outputs go to 0 immediately (asynchronously);
  - after reset is released with both requesters active, r0 is granted first.
